// File: rtl/rr_mux_nx1.sv
// rr_mux_nx1: N-input valid/ready multiplexer with a registered output stage.
// Define RR_MUX_ROUND_ROBIN_EN for round-robin arbitration; without it the lowest-index valid channel wins.
`timescale 1ns/1ps

module rr_mux_nx1 #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         in_valid_i,
    input  logic [N*WIDTH-1:0]   in_data_i,
    output logic [N-1:0]         in_ready_o,
    output logic                 out_valid_o,
    output logic [WIDTH-1:0]     out_data_o,
    output logic [SEL_W-1:0]     out_sel_o,
    input  logic                 out_ready_i
);

    localparam int               CNT_W       = SEL_W + 1;
    localparam logic [CNT_W-1:0] N_EXT       = CNT_W'(N);
    localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(N - 1);
    localparam logic [N-1:0]     ONE_HOT_LSB = {{(N-1){1'b0}}, 1'b1};

    logic                 load_s;
    logic                 xfer_s;
    logic [N-1:0]         grant_s;
    logic [SEL_W-1:0]     grant_idx_s;
    logic                 grant_any_s;
    logic                 hit_s;
    logic [CNT_W-1:0]     cand_s;
    logic [SEL_W-1:0]     ptr_s;
    logic [WIDTH-1:0]     data_mux_s;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0]     out_sel_q,   out_sel_d;

    // The output register can accept a word when empty or when its word drains this cycle.
    assign load_s = ~out_valid_q | out_ready_i;
    assign xfer_s = grant_any_s & load_s;

    // Search channels starting at the pointer and wrapping modulo N; first valid one wins.
    always_comb begin
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        hit_s       = 1'b0;
        cand_s      = '0;
        for (int k = 0; k < N; k++) begin
            cand_s      = {1'b0, ptr_s} + CNT_W'(k);
            cand_s      = (cand_s >= N_EXT) ? (cand_s - N_EXT) : cand_s;
            hit_s       = ~grant_any_s & in_valid_i[cand_s[SEL_W-1:0]];
            grant_idx_s = hit_s ? cand_s[SEL_W-1:0] : grant_idx_s;
            grant_any_s = grant_any_s | hit_s;
        end
        grant_s = grant_any_s ? (ONE_HOT_LSB << grant_idx_s) : {N{1'b0}};
    end

    assign in_ready_o = grant_s & {N{load_s & ~rst_i}};

    // AND-OR data select driven by the one-hot grant.
    always_comb begin
        data_mux_s = '0;
        for (int k = 0; k < N; k++) begin
            data_mux_s = data_mux_s | (in_data_i[k*WIDTH +: WIDTH] & {WIDTH{grant_s[k]}});
        end
    end

    // Output register next state: load on transfer, clear valid on a bare drain, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = data_mux_s;
            out_sel_d   = grant_idx_s;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

`ifdef RR_MUX_ROUND_ROBIN_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Pointer moves one past the granted channel, wrapping at N-1 rather than at 2^SEL_W.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer_s) begin
            ptr_d = (grant_idx_s == LAST_IDX) ? {SEL_W{1'b0}} : (grant_idx_s + SEL_W'(1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_s = ptr_q;
`else
    assign ptr_s = {SEL_W{1'b0}};
`endif

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

`ifndef SYNTHESIS
    rr_mux_nx1_chk #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_i  (in_ready_o),
        .out_valid_i (out_valid_o),
        .out_data_i  (out_data_o),
        .out_sel_i   (out_sel_o),
        .out_ready_i (out_ready_i)
    );
`endif

endmodule

// Protocol checker: grant exclusivity, output stall stability and producer hold rules.
module rr_mux_nx1_chk #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         in_valid_i,
    input  logic [N*WIDTH-1:0]   in_data_i,
    input  logic [N-1:0]         in_ready_i,
    input  logic                 out_valid_i,
    input  logic [WIDTH-1:0]     out_data_i,
    input  logic [SEL_W-1:0]     out_sel_i,
    input  logic                 out_ready_i
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

    a_ready_onehot: assert property (@(posedge clk_i) $onehot0(in_ready_i));

    a_ready_in_reset: assert property (@(posedge clk_i) rst_i |-> (in_ready_i == {N{1'b0}}));

    a_sel_range: assert property (@(posedge clk_i) disable iff (rst_i) out_sel_i <= LAST_IDX);

    a_stall_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_i && !out_ready_i) |=> (out_valid_i && $stable(out_data_i) && $stable(out_sel_i)));

    a_no_ready_on_stall: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_i && !out_ready_i) |-> (in_ready_i == {N{1'b0}}));

    for (genvar g = 0; g < N; g++) begin : g_hold
        a_producer_hold: assert property (@(posedge clk_i) disable iff (rst_i)
            (in_valid_i[g] && !in_ready_i[g]) |=>
            (in_valid_i[g] && $stable(in_data_i[g*WIDTH +: WIDTH])));
    end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Randomized bench for rr_mux_nx1 against a queue-based reference model of the arbitration rules.
`timescale 1ns/1ps

module tb_rr_mux_nx1;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = $clog2(N);
`ifdef RR_MUX_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_ready;

    always #5 clk = ~clk;

    rr_mux_nx1 #(.N(N), .WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_sel_o   (out_sel),
        .out_ready_i (out_ready)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: per-producer pending words, pointer and output register contents.
    logic [WIDTH-1:0] pend [N][$];
    int               m_ptr   = 0;
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_sel   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_grant();
        int c;
        for (int k = 0; k < N; k++) begin
            c = RR ? ((m_ptr + k) % N) : k;
            if (pend[c].size() != 0) return c;
        end
        return -1;
    endfunction

    task automatic drive(input bit r, input bit ordy);
        rst       = r;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            in_valid[i] = (pend[i].size() != 0);
            in_data[i*WIDTH +: WIDTH] = (pend[i].size() != 0) ? pend[i][0] : WIDTH'($urandom);
        end
    endtask

    task automatic cycle(input bit r, input bit ordy);
        int           g;
        bit           ld;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        drive(r, ordy);
        #1;
        if (r) begin
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_out_data", out_data, 0);
            check_eq("rst_out_sel", out_sel, 0);
        end
        g       = model_grant();
        ld      = !m_valid || ordy;
        exp_rdy = (!r && ld && g >= 0) ? (N'(1) << g) : '0;
        check_eq("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
            m_ptr   = 0;
        end else if (ld && g >= 0) begin
            m_data  = pend[g].pop_front();
            m_sel   = g;
            m_valid = 1'b1;
            if (RR) m_ptr = (g + 1) % N;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check_eq("out_valid", out_valid, m_valid);
        check_eq("out_data", out_data, m_data);
        check_eq("out_sel", out_sel, m_sel);
    endtask

    initial begin
        int remaining;
        rst       = 1'b1;
        out_ready = 1'b0;
        in_valid  = '0;
        in_data   = '0;

        // Reset with every channel requesting, then fairness over two full rotations.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) pend[i].push_back(WIDTH'(8'h10 + i));
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        for (int c = 0; c < 10; c++) cycle(1'b0, 1'b1);

        // Single channel, then pointer wrap and skip.
        pend[2].push_back(8'hA5);
        cycle(1'b0, 1'b1);
        pend[1].push_back(8'h3C);
        cycle(1'b0, 1'b1);
        pend[0].push_back(8'h5A);
        pend[3].push_back(8'hC3);
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1);

        // Backpressure with all channels pending.
        for (int i = 0; i < N; i++) begin
            pend[i].push_back(WIDTH'(8'h20 + i));
            pend[i].push_back(WIDTH'(8'h30 + i));
        end
        cycle(1'b0, 1'b1);
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0);
        for (int c = 0; c < 10; c++) cycle(1'b0, 1'b1);

        // Channels 1 and 3 competing continuously.
        for (int r = 0; r < 4; r++) begin
            pend[1].push_back(WIDTH'(8'h40 + r));
            pend[3].push_back(WIDTH'(8'h50 + r));
        end
        for (int c = 0; c < 6; c++) cycle(1'b0, 1'b1);

        // Mid-stream reset while a word sits in the output register.
        pend[0].push_back(8'h77);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        for (int c = 0; c < 6; c++) cycle(1'b0, 1'b1);

        // Random traffic, random backpressure and rare resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (pend[i].size() < 4 && $urandom_range(0, 3) == 0)
                    pend[i].push_back(WIDTH'($urandom));
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
        end

        // Flush: every pending word must be accepted within a bounded number of cycles.
        for (int c = 0; c < 100; c++) cycle(1'b0, 1'b1);
        remaining = 0;
        for (int i = 0; i < N; i++) remaining += pend[i].size();
        check_eq("flush_remaining", remaining, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux_nx1.md
Name: rr_mux_nx1

Overview:
- Parametrised successor to the team's 2:1 mux: N-input, WIDTH-bit multiplexer with a valid/ready handshake on every port and a registered output stage.
- Selection is arbitrated by a round-robin pointer instead of an external select line.
- Used where several producers share one downstream consumer, for example merging N sensor or UART byte streams into one sink.

Parameters:
- N, 4: number of input channels; legal range 2..16.
- WIDTH, 8: data width per channel in bits; legal range 1..64.
- SEL_W, $clog2(N): width of the channel index. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*WIDTH  flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready. At most one bit is high in any cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered output word.
- out_sel  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  downstream is accepting the word.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst high):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 while rst is high.
- Load enable: load = ~out_valid | out_ready. A word can enter the output register in the same cycle the current word drains, so a continuous stream gives full throughput.
- Grant (combinational):
  - Among channels with in_valid=1, pick the first index at or after ptr, searching ptr, ptr+1, ... N-1, 0, ... ptr-1 with wrap-around.
  - grant is one-hot, or all-zero when no channel is valid.
  - in_ready[i] = grant[i] & load & ~rst.
- Transfer on channel i: in_valid[i] & in_ready[i] at a rising clock edge. On the same edge:
  - out_data <= channel i data.
  - out_sel <= i.
  - out_valid <= 1.
  - ptr <= (i+1) mod N, wrapping N-1 to 0.
- Drain with no new transfer: out_valid & out_ready and no grant → out_valid <= 0. out_data and out_sel keep their last values.
- Stall: out_valid & ~out_ready → in_ready is all-zero; out_valid, out_data, out_sel and ptr hold.
- ptr changes only on a transfer. Idle cycles leave it unchanged.
- Latency: 1 clock from input transfer to out_valid high.
- Input protocol:
  - A producer holds in_valid and in_data stable until it is granted.
  - The block never drops or duplicates a word.
  - The block's behaviour is undefined if a producer deasserts in_valid early; assertions flag it in simulation.
- Fairness: with all N channels valid continuously and out_ready=1, grants cycle 0,1,...,N-1,0,... with one transfer per clock.
- Reset asserted mid-stream: the word in the output register is discarded, out_valid falls immediately, and ptr returns to 0.
- Non-power-of-two N: out_sel never exceeds N-1, and pointer wrap goes to 0, not to 2^SEL_W.

Optional Feature:
- Macro: RR_MUX_ROUND_ROBIN_EN.
- Defined: round-robin arbitration exactly as described in Behaviour.
- Undefined:
  - Fixed priority: the lowest-index valid channel always wins.
  - ptr is not implemented and is treated as constant 0.
  - All other handshake, latency and reset behaviour is identical.
- Default build defines the macro.

Test Plan (N=4, WIDTH=8, macro defined unless stated):
- Reset: rst=1 for 2 cycles with in_valid=4'b1111 → out_valid=0, out_data=8'h00, out_sel=0, in_ready=4'b0000. Release rst → first grant is channel 0.
- Single channel: only ch2 valid with data 8'hA5 and out_ready=1 → in_ready=4'b0100 for one cycle, next cycle out_valid=1, out_data=8'hA5, out_sel=2, then ptr=3.
- Fairness: all channels valid with data 8'h10/8'h11/8'h12/8'h13 and out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3 and one word per cycle.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 → out_data and out_sel stable, in_ready=0. Raise out_ready → next channel in rotation is granted in that same cycle.
- Pointer wrap and skip: ptr=3, only ch1 valid → grant ch1, next ptr=2. Then ch0 and ch3 valid → grant ch3, next ptr=0.
- Fixed-priority build (macro undefined): ch1 and ch3 valid continuously → out_sel stays 1 every cycle and ch3 is never granted.
